// File: rtl/alu_mul_seq_if.sv
// Control handshake plus ALU operand/result bus for the shift-and-add multiplier.
interface alu_mul_seq_if;
  logic        start_i;
  logic [7:0]  mcand_i;
  logic [7:0]  mplier_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] product_o;
  logic [7:0]  alu_a_o;
  logic [7:0]  alu_b_o;
  logic [3:0]  alu_op_o;
  logic [7:0]  alu_r_i;

  modport slave (
    input  start_i, mcand_i, mplier_i, alu_r_i,
    output busy_o, done_o, product_o, alu_a_o, alu_b_o, alu_op_o
  );
  modport master (
    output start_i, mcand_i, mplier_i, alu_r_i,
    input  busy_o, done_o, product_o, alu_a_o, alu_b_o, alu_op_o
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned 8x8 -> 16 shift-and-add multiplier that borrows an external combinational ALU
// for the add and shift steps; carry out of the add is recovered locally.
module alu_mul_seq #(
  parameter logic [3:0] OP_ADD  = 4'd0,
  parameter logic [3:0] OP_PASS = 4'd7,
  parameter logic [3:0] OP_SHR  = 4'd10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  alu_mul_seq_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHR, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  m_q, m_d, p_q, p_d, q_q, q_d;
  logic        c_q, c_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] prod_q, prod_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_q     <= p_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    p_d          = p_q;
    q_d          = q_q;
    c_d          = c_q;
    cnt_d        = cnt_q;
    prod_d       = prod_q;
    bus.alu_a_o  = '0;
    bus.alu_b_o  = '0;
    bus.alu_op_o = OP_PASS;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_i) begin
          m_d     = bus.mcand_i;
          q_d     = bus.mplier_i;
          p_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        bus.alu_a_o  = p_q;
        bus.alu_b_o  = m_q;
        bus.alu_op_o = q_q[0] ? OP_ADD : OP_PASS;
        p_d          = bus.alu_r_i;
        // The ALU has no carry out: an 8-bit add wrapped iff the sum is below an operand.
        c_d          = q_q[0] & (bus.alu_r_i < p_q);
        state_d      = S_SHR;
      end
      S_SHR: begin
        bus.alu_a_o  = p_q;
        bus.alu_b_o  = '0;
        bus.alu_op_o = OP_SHR;
        p_d          = {c_q, bus.alu_r_i[6:0]};
        q_d          = {p_q[0], q_q[7:1]};
        c_d          = 1'b0;
        if (cnt_q == 3'd7) begin
          prod_d  = {c_q, bus.alu_r_i[6:0], p_q[0], q_q[7:1]};
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = S_ADD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy_o    = (state_q == S_ADD) || (state_q == S_SHR);
  assign bus.done_o    = (state_q == S_DONE);
  assign bus.product_o = prod_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Random and directed multiplies against a*b, with a scoreboard fed by the driver and a
// separate monitor that checks every done pulse, latency, add-step count and held results.
module tb_alu_mul_seq;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd10;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          start_cyc;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  alu_mul_seq_if bus ();

  alu_mul_seq dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  always #5 clk_i = ~clk_i;

  // Reference combinational ALU bound to the sequencer.
  always_comb begin
    case (bus.alu_op_o)
      OP_ADD:  bus.alu_r_i = bus.alu_a_o + bus.alu_b_o;
      OP_PASS: bus.alu_r_i = bus.alu_a_o;
      OP_SHR:  bus.alu_r_i = bus.alu_a_o >> 1;
      default: bus.alu_r_i = 8'h00;
    endcase
  end

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [15:0] last_prod = 16'h0;
  int   busy_cnt = 0;
  int   add_cnt = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Issue one start; returns in cycle 1 of the operation.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    bus.start_i  = 1'b1;
    bus.mcand_i  = a;
    bus.mplier_i = b;
    e.a = a; e.b = b; e.prod = 16'(a) * 16'(b); e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    bus.start_i  = 1'b0;
    bus.mcand_i  = 8'h5A;
    bus.mplier_i = 8'hC3;
  endtask

  // Monitor: sampled on the falling edge, independent of the driver.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      last_prod = 16'h0;
      busy_cnt  = 0;
      add_cnt   = 0;
    end else begin
      if (bus.busy_o) begin
        busy_cnt++;
        if (bus.alu_op_o == OP_ADD) begin
          add_cnt++;
          if (sb.size() != 0) chk("add_operand_b", bus.alu_b_o, sb[0].a);
        end
      end
      if (bus.done_o) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("product", bus.product_o, e.prod);
          chk("latency", cyc - e.start_cyc, 16);
          chk("busy_cycles", busy_cnt, 16);
          chk("add_steps", add_cnt, $countones(e.b));
          last_prod = e.prod;
        end
        busy_cnt = 0;
        add_cnt  = 0;
      end else begin
        chk("product_held", bus.product_o, last_prod);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i  = 1'b0;
    bus.mcand_i  = 8'h00;
    bus.mplier_i = 8'h00;
    rst_ni       = 1'b0;
    wait_cyc(3);
    chk("rst_product", bus.product_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_alu_op", bus.alu_op_o, OP_PASS);
    chk("rst_alu_a", bus.alu_a_o, 0);
    rst_ni = 1'b1;
    wait_cyc(2);

    issue(8'h0D, 8'h0B); wait_cyc(18);
    issue(8'hFF, 8'hFF); wait_cyc(18);
    issue(8'h00, 8'hA5); wait_cyc(18);
    issue(8'hA5, 8'h00); wait_cyc(18);

    // Start pulse mid-operation with different operands must be ignored.
    issue(8'h12, 8'h34);
    wait_cyc(3);
    bus.start_i = 1'b1; bus.mcand_i = 8'hFF; bus.mplier_i = 8'hFF;
    wait_cyc(1);
    bus.start_i = 1'b0;
    wait_cyc(12);
    chk("ignored_start_done", bus.done_o, 1);
    // Back-to-back: start accepted in the DONE cycle.
    issue(8'h03, 8'h05); wait_cyc(18);

    // Reset in cycle 9 aborts at once.
    issue(8'hC7, 8'h9E);
    wait_cyc(8);
    #2;
    rst_ni = 1'b0;
    sb.delete();
    #1;
    chk("abort_product", bus.product_o, 0);
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_done", bus.done_o, 0);
    wait_cyc(2);
    rst_ni = 1'b1;
    wait_cyc(1);
    issue(8'h0D, 8'h0B); wait_cyc(18);

    for (int i = 0; i < 1000; i++) begin
      issue(8'($urandom), 8'($urandom));
      wait_cyc(15);
      if ($urandom_range(1, 0) == 1) wait_cyc(1);
      else wait_cyc(2 + $urandom_range(3, 0));
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) wait_cyc(1);
    chk("queue_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
